// File: rtl/wb_burst_ram.sv
// ============================================================================
// Module   : wb_burst_ram
// Purpose  : Wishbone RAM with classic cycles and linear/wrapping bursts.
//            Define WB_BURST_RAM_ERR_EN to answer out-of-range beats with wb_err_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_burst_ram #(
  parameter int    DW      = 32,
  parameter int    DEPTH   = 1024,
  parameter string MEMFILE = ""
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [31:0]     wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic [DW-1:0]   wb_dat_o
);

  localparam int NB     = DW / 8;
  localparam int LSB    = $clog2(NB);
  localparam int NWORDS = DEPTH / NB;
  localparam int AW     = $clog2(NWORDS);
  localparam int WW     = 32 - LSB;
  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLASSIC = 2'd1,
    S_BURST   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    bte_q, bte_d;
  logic          last_q, last_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] dat_q;
  logic [DW-1:0] mem [NWORDS];

  logic          valid;
  logic          rd_en;
  logic          rd_oor;
  logic          wr_en;
  logic [31:0]   rd_addr;
  logic [31:0]   next_addr;
  logic [WW-1:0] word;
  logic [WW-1:0] word_inc;
  logic [WW-1:0] wrap_mask;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          unused_addr;

  assign valid = wb_cyc_i & wb_stb_i;

  // Wrap bursts only count within the low word-index bits; linear uses a full mask.
  always_comb begin
    wrap_mask = '1;
    case (bte_q)
      2'b01:   wrap_mask = WW'(3);
      2'b10:   wrap_mask = WW'(7);
      2'b11:   wrap_mask = WW'(15);
      default: wrap_mask = '1;
    endcase
    word      = addr_q[31:LSB];
    word_inc  = word + WW'(1);
    next_addr = {(word & ~wrap_mask) | (word_inc & wrap_mask), addr_q[LSB-1:0]};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bte_d   = bte_q;
    last_d  = last_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_q;

    case (state_q)
      S_IDLE: begin
        if (valid) begin
          rd_en   = 1'b1;
          rd_addr = wb_adr_i;
          addr_d  = wb_adr_i;
          bte_d   = wb_bte_i;
          last_d  = 1'b0;
          state_d = (wb_cti_i == CTI_INCR) ? S_BURST : S_CLASSIC;
        end
      end
      S_CLASSIC: begin
        state_d = S_IDLE;
      end
      S_BURST: begin
        if (last_q) begin
          state_d = S_IDLE;
        end else if (valid) begin
          rd_en   = 1'b1;
          rd_addr = next_addr;
          addr_d  = next_addr;
          last_d  = (wb_cti_i != CTI_INCR);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_en) begin
      ack_d = ~rd_oor;
      err_d = rd_oor;
    end

    if (!wb_cyc_i) begin
      state_d = S_IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      rd_en   = 1'b0;
    end
  end

`ifdef WB_BURST_RAM_ERR_EN
  assign rd_oor = |rd_addr[31:LSB+AW];
`else
  assign rd_oor = 1'b0;
`endif

  assign unused_addr = ^{rd_addr[31:LSB+AW], rd_addr[LSB-1:0]};
  assign rd_idx      = rd_addr[LSB +: AW];
  assign wr_idx      = addr_q[LSB +: AW];
  assign wr_en       = ack_q & wb_cyc_i & wb_we_i & ~wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      bte_q   <= '0;
      last_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bte_q   <= bte_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // The prefetch address always differs from the beat being written, so a
  // plain read-first RAM never returns stale data here.
  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_sel_i[b]) begin
          mem[wr_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dat_q <= '0;
    end else if (rd_en) begin
      dat_q <= rd_oor ? '0 : mem[rd_idx];
    end
  end

  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_err_o = err_q & wb_cyc_i;
  assign wb_dat_o = dat_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_burst_ram.sv
// ============================================================================
// Module   : tb_wb_burst_ram
// Purpose  : Directed scoreboard bench for wb_burst_ram (DW=32, DEPTH=1024).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_burst_ram;

  typedef struct packed {
    logic        is_err;
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        wb_ack;
  logic        wb_err;
  logic [31:0] wb_dat_o;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ba[4];
  logic [31:0] bd[4];

  always #5 clk = ~clk;

  wb_burst_ram #(.DW(32), .DEPTH(1024), .MEMFILE("")) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel),
    .wb_we_i  (wb_we),
    .wb_cyc_i (wb_cyc),
    .wb_stb_i (wb_stb),
    .wb_cti_i (wb_cti),
    .wb_bte_i (wb_bte),
    .wb_ack_o (wb_ack),
    .wb_err_o (wb_err),
    .wb_dat_o (wb_dat_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  task automatic bus_idle();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_cti = 3'b000; wb_bte = 2'b00; wb_sel = 4'h0;
  endtask

  // Monitor: every response pops the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (wb_ack && wb_err) report_fail("ack_err_same_cycle", {30'd0, wb_ack, wb_err});
      if (wb_ack || wb_err) begin
        if (sb_q.size() == 0) begin
          report_fail("unexpected_response", wb_dat_o);
        end else begin
          e = sb_q.pop_front();
          check("resp_is_err", {31'd0, wb_err}, {31'd0, e.is_err});
          if (e.chk) check("read_data", wb_dat_o, e.data);
        end
      end
    end
  end

  task automatic classic(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input exp_t e, input string name);
    int n;
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = adr; wb_we = we;
    wb_dat_i = dat; wb_sel = sel; wb_cti = 3'b000; wb_bte = 2'b00;
    sb_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!(wb_ack || wb_err) && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, 1);
    @(posedge clk); #1;
    bus_idle();
  endtask

  // Read burst of four beats from ba[], expecting bd[]; optional stall after a beat.
  task automatic burst(input logic [1:0] bte, input int stall_after, input int stall_len,
                       input logic [7:0] pat, input string name);
    logic [7:0] seen;
    int k;
    int stall;
    seen = 8'h00;
    k = 0;
    stall = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      wb_cyc = 1'b1;
      if (k < 4 && stall == 0) begin
        wb_stb = 1'b1; wb_adr = ba[k]; wb_we = 1'b0; wb_sel = 4'hF;
        wb_cti = (k == 3) ? 3'b111 : 3'b010; wb_bte = bte;
        sb_q.push_back(exp_t'({1'b0, 1'b1, bd[k]}));
        if (k == stall_after) stall = stall_len;
        k++;
      end else begin
        wb_stb = 1'b0;
        if (stall > 0) stall--;
      end
      @(negedge clk);
      seen[c] = wb_ack;
    end
    check({name, "_ack_pattern"}, {24'd0, seen}, {24'd0, pat});
    @(posedge clk); #1;
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; wb_adr = '0; wb_dat_i = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", {31'd0, wb_ack}, 32'd0);
    check("reset_err", {31'd0, wb_err}, 32'd0);
    check("reset_dat", wb_dat_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, exp_t'({1'b0, 1'b0, 32'h0}), "wr_full");
    classic(32'h10, 1'b0, 32'h0, 4'hF, exp_t'({1'b0, 1'b1, 32'hDEADBEEF}), "rd_full");
    classic(32'h10, 1'b1, 32'h000000AA, 4'h1, exp_t'({1'b0, 1'b0, 32'h0}), "wr_byte");
    classic(32'h10, 1'b0, 32'h0, 4'hF, exp_t'({1'b0, 1'b1, 32'hDEADBEAA}), "rd_byte");

    classic(32'h00, 1'b1, 32'hC0DE0000, 4'hF, exp_t'({1'b0, 1'b0, 32'h0}), "fill_0");
    for (int i = 0; i < 8; i++)
      classic(32'h20 + 4 * i, 1'b1, 32'hC0DE0020 + 4 * i, 4'hF,
              exp_t'({1'b0, 1'b0, 32'h0}), "fill");

    // Requests in cycles 0..3 -> acks in cycles 1..4, none in 5..7.
    ba = '{32'h20, 32'h24, 32'h28, 32'h2C};
    bd = '{32'hC0DE0020, 32'hC0DE0024, 32'hC0DE0028, 32'hC0DE002C};
    burst(2'b00, -1, 0, 8'b0001_1110, "linear4");

    ba = '{32'h38, 32'h3C, 32'h30, 32'h34};
    bd = '{32'hC0DE0038, 32'hC0DE003C, 32'hC0DE0030, 32'hC0DE0034};
    burst(2'b01, -1, 0, 8'b0001_1110, "wrap4");

    // Requests in cycles 0,1,2,5 -> acks in 1,2,3,6; ack low in 4 and 5.
    ba = '{32'h20, 32'h24, 32'h28, 32'h2C};
    bd = '{32'hC0DE0020, 32'hC0DE0024, 32'hC0DE0028, 32'hC0DE002C};
    burst(2'b00, 2, 2, 8'b0100_1110, "stall");

`ifdef WB_BURST_RAM_ERR_EN
    classic(32'h400, 1'b0, 32'h0, 4'hF, exp_t'({1'b1, 1'b1, 32'h0}), "rd_oor");
`else
    classic(32'h400, 1'b0, 32'h0, 4'hF, exp_t'({1'b0, 1'b1, 32'hC0DE0000}), "rd_oor");
`endif

    // Dropping cyc in the would-be ack cycle must cancel both ack and write.
    @(posedge clk); #1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = 32'h24; wb_we = 1'b1;
    wb_dat_i = 32'hBAD0BAD0; wb_sel = 4'hF; wb_cti = 3'b000;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("cyc_drop_ack", {31'd0, wb_ack}, 32'd0);
    classic(32'h24, 1'b0, 32'h0, 4'hF, exp_t'({1'b0, 1'b1, 32'hC0DE0024}), "rd_after_drop");

    repeat (3) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
